// File: rtl/fc_classifier_if.sv
// Beat input and score/argmax output bundle for fc_classifier.
// The source drives the master side and the classifier drives the slave side.
interface fc_classifier_if #(
  parameter int DW = 13,
  parameter int AW = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in0, in1, in2, in3, in4, in5, in6, in7, in8, in9;
  logic                 score_valid;
  logic [3:0]           score_idx;
  logic signed [AW-1:0] score;
  logic [3:0]           pred;
  logic                 done;

  modport master (
    output in_valid, in0, in1, in2, in3, in4, in5, in6, in7, in8, in9,
    input  in_ready, score_valid, score_idx, score, pred, done
  );

  modport slave (
    input  in_valid, in0, in1, in2, in3, in4, in5, in6, in7, in8, in9,
    output in_ready, score_valid, score_idx, score, pred, done
  );
endinterface

// File: rtl/fc_classifier.sv
// Fully connected classifier: MACs 36 beats of 10 channels into K class scores, adds bias,
// streams scores out and reports the argmax. ROM word i lives at bits [i*WW +: WW].
module fc_classifier #(
  parameter int L  = 10,
  parameter int P  = 36,
  parameter int K  = 10,
  parameter int DW = 13,
  parameter int WW = 8,
  parameter int BW = 16,
  parameter int AW = 32,
  parameter logic [K*L*P*WW-1:0] W_ROM = {(K*L*P){WW'(1)}},
  parameter logic [K*BW-1:0]     B_ROM = '0
) (
  input logic clk,
  input logic rst,
  fc_classifier_if.slave bus
);

  localparam int KW  = 4;
  localparam int PW  = $clog2(P);
  localparam int PRW = DW + WW;
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [PW-1:0] P_LAST = PW'(P - 1);

  typedef enum logic [2:0] {IDLE, MAC, BIAS, OUT, FIN} state_t;

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [PW-1:0]        p_q, p_d;
  logic signed [DW-1:0] x_q [L];
  logic signed [DW-1:0] x_d [L];
  logic signed [DW-1:0] in_bus [L];
  logic signed [AW-1:0] acc_q [K];
  logic signed [AW-1:0] acc_d [K];
  logic signed [AW-1:0] max_q, max_d;
  logic [KW-1:0]        max_idx_q, max_idx_d;
  logic [KW-1:0]        pred_q, pred_d;
  logic                 done_q, done_d;
  logic signed [WW-1:0] w_sel [L];
  logic signed [PRW-1:0] prod [L];
  logic signed [AW-1:0] mac_sum;
  logic signed [AW-1:0] cur_acc;
  logic                 take_max;

  assign in_bus = '{bus.in0, bus.in1, bus.in2, bus.in3, bus.in4,
                    bus.in5, bus.in6, bus.in7, bus.in8, bus.in9};

  // One class per cycle: L parallel products of the latched beat against that class's weights
  always_comb begin
    mac_sum = '0;
    for (int c = 0; c < L; c++) begin
      w_sel[c] = W_ROM[(int'(k_q) * L * P + c * P + int'(p_q)) * WW +: WW];
      prod[c]  = $signed({{WW{x_q[c][DW-1]}}, x_q[c]}) *
                 $signed({{DW{w_sel[c][WW-1]}}, w_sel[c]});
      mac_sum  = mac_sum + AW'(prod[c]);
    end
  end

  // Strict compare keeps the lowest index on ties
  assign cur_acc  = acc_q[k_q];
  assign take_max = (k_q == '0) || (cur_acc > max_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = MAC;
      MAC:     if (k_q == K_LAST) state_d = (p_q == P_LAST) ? BIAS : IDLE;
      BIAS:    state_d = OUT;
      OUT:     if (k_q == K_LAST) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    k_d       = k_q;
    p_d       = p_q;
    x_d       = x_q;
    acc_d     = acc_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
    pred_d    = pred_q;
    done_d    = done_q;
    case (state_q)
      IDLE: begin
        k_d = '0;
        if (bus.in_valid) begin
          x_d = in_bus;
          if (p_q == '0) begin
            done_d = 1'b0;
            for (int i = 0; i < K; i++) acc_d[i] = '0;
          end
        end
      end
      MAC: begin
        acc_d[k_q] = acc_q[k_q] + mac_sum;
        if (k_q == K_LAST) begin
          k_d = '0;
          p_d = (p_q == P_LAST) ? '0 : p_q + PW'(1);
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      BIAS: begin
        for (int i = 0; i < K; i++)
          acc_d[i] = acc_q[i] + AW'($signed(B_ROM[i*BW +: BW]));
      end
      OUT: begin
        if (take_max) begin
          max_d     = cur_acc;
          max_idx_d = k_q;
        end
        if (k_q == K_LAST) begin
          k_d    = '0;
          done_d = 1'b1;
          pred_d = take_max ? k_q : max_idx_q;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q       <= '0;
      p_q       <= '0;
      max_q     <= '0;
      max_idx_q <= '0;
      pred_q    <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < L; i++) x_q[i] <= '0;
      for (int i = 0; i < K; i++) acc_q[i] <= '0;
    end else begin
      k_q       <= k_d;
      p_q       <= p_d;
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
      pred_q    <= pred_d;
      done_q    <= done_d;
      x_q       <= x_d;
      acc_q     <= acc_d;
    end
  end

  always_comb begin
    bus.in_ready    = (state_q == IDLE);
    bus.score_valid = (state_q == OUT);
    bus.score_idx   = '0;
    bus.score       = '0;
    if (state_q == OUT) begin
      bus.score_idx = k_q;
      bus.score     = cur_acc;
    end
    bus.pred = pred_q;
    bus.done = done_q;
  end

endmodule
